data_memory_arbiter: RTL

- Sequences the single data-memory port between two requesters: the load unit and the store-buffer drain (pull) channel.
- Loads have priority, bounded by a store-starvation counter; stores win on fence or load/store-buffer address hazards.
- Tracks one outstanding memory transaction at a time.
- Sits between the load unit, the store buffer pull channel and the bus controller.

---
 rtl/data_memory_arbiter_pkg.sv | 19 +
 rtl/data_memory_arbiter_starve_cnt.sv | 31 +++
 rtl/data_memory_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared memory-system types for the data-memory arbiter: FSM encoding,
// access width type and the default store-starvation limit.
package data_memory_arbiter_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned ARB_STATE_W      = 3;

  typedef logic [ARB_STATE_W-1:0] arb_state_t;

  localparam arb_state_t ST_IDLE     = 3'd0;
  localparam arb_state_t ST_ISSUE_LD = 3'd1;
  localparam arb_state_t ST_WAIT_LD  = 3'd2;
  localparam arb_state_t ST_ISSUE_ST = 3'd3;
  localparam arb_state_t ST_WAIT_ST  = 3'd4;

  // Same encoding as the store buffer's width field (byte/half/word).
  typedef logic [1:0] mem_width_t;

endpackage

// File: rtl/data_memory_arbiter_starve_cnt.sv
// Saturating count of consecutive load grants taken while a store waits;
// at_limit_c tells the arbiter to force the next grant to the store.
module data_memory_arbiter_starve_cnt
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic inc,
  output logic at_limit_c
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_limit_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign at_limit_c = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single data-memory port between the load unit and the
// store-buffer drain channel, one outstanding transaction at a time.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              fence_i,
  output logic              fence_done_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [1:0]        ld_width_i,
  input  logic              ld_fwd_hit_i,
  output logic              ld_done_o,
  output logic [DATA_W-1:0] ld_data_o,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [1:0]        st_width_i,
  input  logic              st_empty_i,
  output logic              st_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        mem_width_o,
  input  logic              mem_ack_i,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t state_q, state_d;
  logic       kill_q, kill_d;
  logic       grant_ld, grant_st;
  logic       drop_req, ld_fin, st_fin;
  logic       cnt_clr, cnt_inc;
  logic       at_limit_c;

  data_memory_arbiter_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .at_limit_c (at_limit_c)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Grant selection, handshake sequencing and flush bookkeeping.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    drop_req = 1'b0;
    ld_fin   = 1'b0;
    st_fin   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (st_req_i && (fence_i || at_limit_c || (ld_req_i && ld_fwd_hit_i))) begin
          grant_st = 1'b1;
        end else if (ld_req_i && !fence_i && !flush_i && !ld_fwd_hit_i) begin
          grant_ld = 1'b1;
        end else if (st_req_i) begin
          grant_st = 1'b1;
        end
        if (grant_st) begin
          state_d = ST_ISSUE_ST;
          cnt_clr = 1'b1;
        end else if (grant_ld) begin
          state_d = ST_ISSUE_LD;
          cnt_inc = st_req_i;
          cnt_clr = !st_req_i;
        end else begin
          cnt_clr = !st_req_i;
        end
      end
      ST_ISSUE_LD: begin
        if (mem_ack_i) begin
          drop_req = 1'b1;
          if (mem_done_i) begin
            ld_fin  = !flush_i;
            state_d = ST_IDLE;
          end else begin
            kill_d  = flush_i;
            state_d = ST_WAIT_LD;
          end
        end else if (flush_i) begin
          drop_req = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_LD: begin
        // An accepted load cannot be recalled; a flush only hides its result.
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (mem_done_i) begin
          ld_fin  = !(kill_q || flush_i);
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE_ST: begin
        if (mem_ack_i) begin
          drop_req = 1'b1;
          if (mem_done_i) begin
            st_fin  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_ST;
          end
        end
      end
      ST_WAIT_ST: begin
        if (mem_done_i) begin
          st_fin  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered memory-port and requester outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_width_o  <= '0;
      ld_done_o    <= 1'b0;
      ld_data_o    <= '0;
      st_done_o    <= 1'b0;
      fence_done_o <= 1'b0;
    end else begin
      ld_done_o    <= ld_fin;
      st_done_o    <= st_fin;
      fence_done_o <= fence_i && st_empty_i && (state_q == ST_IDLE);
      if (ld_fin) begin
        ld_data_o <= mem_rdata_i;
      end
      if (grant_st) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b1;
        mem_addr_o  <= st_addr_i;
        mem_wdata_o <= st_data_i;
        mem_width_o <= st_width_i;
      end else if (grant_ld) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= ld_addr_i;
        mem_wdata_o <= '0;
        mem_width_o <= ld_width_i;
      end else if (drop_req) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule
